// File: rtl/result_matrix_streamer.sv
// Drains product matrix R row-major from the multiplier read port onto a stb/ack stream.
// Latency: out_stb 3 edges after start (mm_done high), 2 cycles/element; holds element while out_ack is low.
module result_matrix_streamer #(
  parameter int n     = 4,
  parameter int n_len = $clog2(n)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mm_done,
  output logic [n_len-1:0] z_i,
  output logic [n_len-1:0] z_j,
  input  logic [31:0]      z_out,
  output logic [31:0]      out_data,
  output logic [n_len-1:0] out_row,
  output logic [n_len-1:0] out_col,
  output logic             out_last,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, WAIT, FETCH, SEND, DONE_ST} state_t;

  localparam logic [n_len-1:0] last_idx = n_len'(n - 1);

  state_t           state, state_nxt;
  logic [n_len-1:0] row, row_nxt;
  logic [n_len-1:0] col, col_nxt;
  logic [n_len-1:0] z_i_nxt, z_j_nxt;
  logic [31:0]      out_data_nxt;
  logic [n_len-1:0] out_row_nxt, out_col_nxt;
  logic             out_last_nxt, out_stb_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      z_i      <= '0;
      z_j      <= '0;
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
      out_last <= 1'b0;
      out_stb  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      row      <= row_nxt;
      col      <= col_nxt;
      z_i      <= z_i_nxt;
      z_j      <= z_j_nxt;
      out_data <= out_data_nxt;
      out_row  <= out_row_nxt;
      out_col  <= out_col_nxt;
      out_last <= out_last_nxt;
      out_stb  <= out_stb_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    row_nxt      = row;
    col_nxt      = col;
    z_i_nxt      = z_i;
    z_j_nxt      = z_j;
    out_data_nxt = out_data;
    out_row_nxt  = out_row;
    out_col_nxt  = out_col;
    out_last_nxt = out_last;
    out_stb_nxt  = out_stb;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end
      WAIT: begin
        if (mm_done) begin
          state_nxt = FETCH;
          z_i_nxt   = row;
          z_j_nxt   = col;
        end
      end
      FETCH: begin
        out_data_nxt = z_out;
        out_row_nxt  = row;
        out_col_nxt  = col;
        out_last_nxt = (row == last_idx) && (col == last_idx);
        out_stb_nxt  = 1'b1;
        state_nxt    = SEND;
      end
      SEND: begin
        if (out_ack) begin
          out_stb_nxt = 1'b0;
          if (out_last) begin
            out_last_nxt = 1'b0;
            done_nxt     = 1'b1;
            state_nxt    = DONE_ST;
          end else begin
            // Column wraps to 0 on its own since n is a power of two.
            col_nxt   = col + 1'b1;
            row_nxt   = (col == last_idx) ? row + 1'b1 : row;
            z_j_nxt   = col + 1'b1;
            z_i_nxt   = (col == last_idx) ? row + 1'b1 : row;
            state_nxt = FETCH;
          end
        end
      end
      DONE_ST: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_result_matrix_streamer.sv
// Directed bench: a behavioural result store feeds z_out, a scoreboard checks the row-major stream.
module tb_result_matrix_streamer;

  localparam int n     = 4;
  localparam int n_len = 2;

  logic             clk = 1'b0;
  logic             rst, start, mm_done, out_ack;
  logic [n_len-1:0] z_i, z_j, out_row, out_col;
  logic [31:0]      z_out, out_data;
  logic             out_last, out_stb, busy, done;

  logic [31:0] mat [n][n];
  int total = 0;
  int bad   = 0;

  assign z_out = mat[z_i][z_j];

  always #5 clk = ~clk;

  result_matrix_streamer #(.n(n), .n_len(n_len)) dut (
    .clk(clk), .rst(rst), .start(start), .mm_done(mm_done),
    .z_i(z_i), .z_j(z_j), .z_out(z_out),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .out_stb(out_stb), .out_ack(out_ack),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stb"},  out_stb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_rc"},   {out_row, out_col, out_last}, 0);
    chk({tag, "_zij"},  {z_i, z_j}, 0);
  endtask

  // Pulse start, then take the WAIT->FETCH edge (mm_done must be high).
  task automatic begin_stream;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_in_wait", busy, 1);
    tick();
  endtask

  // mode 0: ack tied high; 1: ack held low 5 cycles on element 9;
  // 2: ack high in FETCH, low on first SEND cycle, start pulsed in SEND.
  task automatic stream(input int mode, input int exp_done_edge);
    int ei = 0, held = 0, first_stb = -1, done_edge = -1, ndone = 0;
    bit waited = 1'b0;
    for (int c = 1; c <= 200 && done_edge < 0; c++) begin
      start = 1'b0;
      if (mode == 1) begin
        if (out_stb && ei == 9 && held < 5) begin
          out_ack = 1'b0;
          held++;
          chk("hold_dat", {out_stb, out_row, out_col, out_data}, {1'b1, 2'd2, 2'd1, 32'h21});
        end else begin
          out_ack = 1'b1;
        end
      end else if (mode == 2) begin
        if (out_stb && !waited) begin
          out_ack = 1'b0;
          waited  = 1'b1;
          if (ei == 5) start = 1'b1;
        end else begin
          out_ack = 1'b1;
        end
      end else begin
        out_ack = 1'b1;
      end

      if (out_stb && out_ack) begin
        if (ei < n * n) begin
          chk("xfer_data", out_data, mat[ei / n][ei % n]);
          chk("xfer_row",  out_row, ei / n);
          chk("xfer_col",  out_col, ei % n);
          chk("xfer_last", out_last, (ei == n * n - 1));
        end else begin
          chk("extra_xfer", ei, n * n - 1);
        end
        ei++;
        waited = 1'b0;
      end

      tick();
      if (out_stb && first_stb < 0) first_stb = c;
      if (done) begin
        ndone++;
        done_edge = c;
      end
    end
    out_ack = 1'b1;
    start   = 1'b0;
    tick();
    chk("busy_after_done", busy, 0);
    chk("done_after_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("idle_stb", out_stb, 0);
    chk("xfer_count", ei, n * n);
    chk("done_pulses", ndone, 1);
    chk("first_stb_edge", first_stb, 1);
    if (exp_done_edge >= 0) chk("done_edge", done_edge, exp_done_edge);
  endtask

  initial begin
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        mat[i][j] = 32'(16 * i + j);

    rst = 1'b1; start = 1'b0; mm_done = 1'b0; out_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_all_zero("reset");

    // Basic drain with ack tied high.
    mm_done = 1'b1;
    begin_stream();
    stream(0, 32);

    // Start waits for mm_done.
    mm_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("wait_stb", out_stb, 0);
      chk("wait_busy", busy, 1);
    end
    mm_done = 1'b1;
    tick();
    chk("leave_wait_stb", out_stb, 0);
    stream(0, 32);

    // Backpressure on element (2,1).
    begin_stream();
    stream(1, 37);

    // Spurious start during SEND and ack during FETCH.
    begin_stream();
    stream(2, 48);

    // Reset while element (1,2) is being offered.
    begin_stream();
    out_ack = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (out_stb && out_row == 2'd1 && out_col == 2'd2) break;
    end
    out_ack = 1'b0;
    chk("pre_rst_stb", out_stb, 1);
    chk("pre_rst_data", out_data, 32'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("mid_rst");
    tick();
    chk("mid_rst_no_done", done, 0);
    begin_stream();
    stream(0, 32);

    // Extreme values; mm_done dropping mid-pass must not stop the stream.
    mat[3][3] = 32'hFFFF_FFFF;
    mat[0][0] = 32'h8000_0000;
    begin_stream();
    mm_done = 1'b0;
    stream(0, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
